// File: rtl/univ_shift_register.sv
// Universal WIDTH-bit register: hold, load, shift, rotate and clear, with serial out and a saturating shift counter.
// Optional registered parity output `par` is present when SHREG_PARITY_EN is defined.
module univ_shift_register #(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       en,
    input  logic [2:0]                 mode,
    input  logic [WIDTH-1:0]           d,
    input  logic                       sin,
    output logic [WIDTH-1:0]           q,
    output logic                       sout,
    output logic [$clog2(WIDTH+1)-1:0] cnt,
    output logic                       done
`ifdef SHREG_PARITY_EN
    ,
    output logic                       par
`endif
);

    localparam int             CW      = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]  CNT_MAX = CW'(WIDTH);

    typedef enum logic [2:0] {
        M_HOLD  = 3'b000,
        M_LOAD  = 3'b001,
        M_SHL   = 3'b010,
        M_SHR   = 3'b011,
        M_ROTL  = 3'b100,
        M_ROTR  = 3'b101,
        M_CLEAR = 3'b110,
        M_RSVD  = 3'b111
    } mode_t;

    mode_t            mode_e;
    logic [WIDTH-1:0] q_r, q_nxt;
    logic             sout_r, sout_nxt;
    logic [CW-1:0]    cnt_r, cnt_nxt;
    logic             shift_op;

    assign mode_e = mode_t'(mode);

    always_comb begin
        q_nxt    = q_r;
        sout_nxt = sout_r;
        cnt_nxt  = cnt_r;
        shift_op = 1'b0;
        if (en) begin
            case (mode_e)
                M_LOAD: begin
                    q_nxt   = d;
                    cnt_nxt = '0;
                end
                M_SHL: begin
                    q_nxt    = {q_r[WIDTH-2:0], sin};
                    sout_nxt = q_r[WIDTH-1];
                    shift_op = 1'b1;
                end
                M_SHR: begin
                    q_nxt    = {sin, q_r[WIDTH-1:1]};
                    sout_nxt = q_r[0];
                    shift_op = 1'b1;
                end
                M_ROTL: begin
                    q_nxt    = {q_r[WIDTH-2:0], q_r[WIDTH-1]};
                    sout_nxt = q_r[WIDTH-1];
                    shift_op = 1'b1;
                end
                M_ROTR: begin
                    q_nxt    = {q_r[0], q_r[WIDTH-1:1]};
                    sout_nxt = q_r[0];
                    shift_op = 1'b1;
                end
                M_CLEAR: begin
                    q_nxt    = '0;
                    sout_nxt = 1'b0;
                    cnt_nxt  = '0;
                end
                default: ;
            endcase
            // Data keeps moving once saturated; only the count stops.
            if (shift_op && (cnt_r != CNT_MAX))
                cnt_nxt = cnt_r + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            q_r    <= RESET_VAL;
            sout_r <= 1'b0;
            cnt_r  <= '0;
        end else begin
            q_r    <= q_nxt;
            sout_r <= sout_nxt;
            cnt_r  <= cnt_nxt;
        end
    end

`ifdef SHREG_PARITY_EN
    logic par_r;

    // Computed from the next value so par tracks q with no extra latency.
    always_ff @(posedge clk) begin
        if (!reset)
            par_r <= ^RESET_VAL;
        else
            par_r <= ^q_nxt;
    end

    assign par = par_r;
`endif

    assign q    = q_r;
    assign sout = sout_r;
    assign cnt  = cnt_r;
    assign done = (cnt_r == CNT_MAX);

endmodule
